// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and control-bundle types for the
// pipelined RV32I control unit.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R           = 7'b0110011;
    localparam logic [6:0] OP_I           = 7'b0010011;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_LEGACY_ADDI = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic       alu_en;
        logic       add_imm;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_bundle_t;

    // Only the fields still needed once an instruction has left EX.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: RV32I instruction word to control bundle,
// register fields and an rs2-used indication for hazard detection.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned LEGACY_ADDI_EN = 1,
    parameter int unsigned RF_ADDR_W      = 5
) (
    input  logic [31:0]          i_instr,
    output ctrl_bundle_t         o_ctrl,
    output logic [RF_ADDR_W-1:0] o_rd,
    output logic [RF_ADDR_W-1:0] o_rs1,
    output logic [RF_ADDR_W-1:0] o_rs2,
    output logic                 o_rs2_used
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_b5;

    assign w_opcode    = i_instr[6:0];
    assign w_funct3    = i_instr[14:12];
    assign w_funct7_b5 = i_instr[30];
    assign o_rd        = i_instr[7  +: RF_ADDR_W];
    assign o_rs1       = i_instr[15 +: RF_ADDR_W];
    assign o_rs2       = i_instr[20 +: RF_ADDR_W];

    always_comb begin
        o_ctrl     = CTRL_NOP;
        o_rs2_used = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_ctrl.alu_en    = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = {w_funct7_b5, w_funct3};
                o_rs2_used       = 1'b1;
            end
            OP_I: begin
                o_ctrl.alu_en    = 1'b1;
                o_ctrl.add_imm   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                // Only the right-shift immediate carries an op bit in funct7.
                o_ctrl.alu_op    = (w_funct3 == 3'b101) ? {w_funct7_b5, 3'b101}
                                                        : {1'b0, w_funct3};
            end
            OP_LEGACY_ADDI: begin
                if (LEGACY_ADDI_EN != 0) begin
                    o_ctrl.alu_en    = 1'b1;
                    o_ctrl.add_imm   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.alu_op    = ALU_ADD;
                end else begin
                    o_ctrl.illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                o_ctrl.add_imm    = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.add_imm   = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.mem_write = 1'b1;
                o_rs2_used       = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.branch = 1'b1;
                o_rs2_used    = 1'b1;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
        if (o_rd == '0) begin
            o_ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// EX/MEM/WB control pipeline with per-stage valids, global stall, EX flush
// and load-use hazard detection around the combinational ID decoder.
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned LEGACY_ADDI_EN = 1,
    parameter int unsigned RF_ADDR_W      = 5,
    parameter int unsigned HAZARD_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    input  logic                 stall_in,
    input  logic                 flush_in,
    output logic                 hazard_stall,
    output logic                 ex_valid,
    output logic                 ex_alu_en,
    output logic                 ex_add_imm,
    output logic [3:0]           ex_alu_op,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_illegal,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic                 mem_valid,
    output logic                 mem_mem_read,
    output logic                 mem_mem_write,
    output logic                 mem_reg_write_en,
    output logic [RF_ADDR_W-1:0] mem_rd,
    output logic                 wb_valid,
    output logic                 wb_reg_write_en,
    output logic                 wb_mem_to_reg,
    output logic [RF_ADDR_W-1:0] wb_rd
);

    ctrl_bundle_t         w_dec_ctrl;
    logic [RF_ADDR_W-1:0] w_dec_rd;
    logic [RF_ADDR_W-1:0] w_dec_rs1;
    logic [RF_ADDR_W-1:0] w_dec_rs2;
    logic                 w_dec_rs2_used;
    logic                 w_hazard;
    logic                 w_ex_load;

    ctrl_bundle_t         r_ex_ctrl;
    logic                 r_ex_valid;
    logic [RF_ADDR_W-1:0] r_ex_rd;
    mem_ctrl_t            r_mem_ctrl;
    logic                 r_mem_valid;
    logic [RF_ADDR_W-1:0] r_mem_rd;
    wb_ctrl_t             r_wb_ctrl;
    logic                 r_wb_valid;
    logic [RF_ADDR_W-1:0] r_wb_rd;

    ctrl_decoder #(
        .LEGACY_ADDI_EN (LEGACY_ADDI_EN),
        .RF_ADDR_W      (RF_ADDR_W)
    ) u_decoder (
        .i_instr    (instr),
        .o_ctrl     (w_dec_ctrl),
        .o_rd       (w_dec_rd),
        .o_rs1      (w_dec_rs1),
        .o_rs2      (w_dec_rs2),
        .o_rs2_used (w_dec_rs2_used)
    );

    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign w_hazard = !rst && instr_valid && r_ex_valid && r_ex_ctrl.mem_read
                              && (r_ex_rd != '0)
                              && ((w_dec_rs1 == r_ex_rd)
                                  || (w_dec_rs2_used && (w_dec_rs2 == r_ex_rd)));
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    // Anything other than a clean valid instruction enters EX as a bubble.
    assign w_ex_load = instr_valid && !flush_in && !w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= CTRL_NOP;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_ctrl   <= '0;
            r_wb_rd     <= '0;
        end else if (!stall_in) begin
            r_ex_valid  <= w_ex_load;
            r_ex_ctrl   <= w_ex_load ? w_dec_ctrl : CTRL_NOP;
            r_ex_rd     <= w_ex_load ? w_dec_rd : '0;
            r_mem_valid <= r_ex_valid;
            r_mem_ctrl  <= '{mem_read:   r_ex_ctrl.mem_read,
                             mem_write:  r_ex_ctrl.mem_write,
                             reg_write:  r_ex_ctrl.reg_write,
                             mem_to_reg: r_ex_ctrl.mem_to_reg};
            r_mem_rd    <= r_ex_rd;
            r_wb_valid  <= r_mem_valid;
            r_wb_ctrl   <= '{reg_write:  r_mem_ctrl.reg_write,
                             mem_to_reg: r_mem_ctrl.mem_to_reg};
            r_wb_rd     <= r_mem_rd;
        end
    end

    assign hazard_stall     = w_hazard;

    assign ex_valid         = r_ex_valid;
    assign ex_alu_en        = r_ex_ctrl.alu_en     & r_ex_valid;
    assign ex_add_imm       = r_ex_ctrl.add_imm    & r_ex_valid;
    assign ex_alu_op        = r_ex_ctrl.alu_op     & {4{r_ex_valid}};
    assign ex_mem_read      = r_ex_ctrl.mem_read   & r_ex_valid;
    assign ex_mem_write     = r_ex_ctrl.mem_write  & r_ex_valid;
    assign ex_branch        = r_ex_ctrl.branch     & r_ex_valid;
    assign ex_illegal       = r_ex_ctrl.illegal    & r_ex_valid;
    assign ex_rd            = r_ex_rd;

    assign mem_valid        = r_mem_valid;
    assign mem_mem_read     = r_mem_ctrl.mem_read  & r_mem_valid;
    assign mem_mem_write    = r_mem_ctrl.mem_write & r_mem_valid;
    assign mem_reg_write_en = r_mem_ctrl.reg_write & r_mem_valid;
    assign mem_rd           = r_mem_rd;

    assign wb_valid         = r_wb_valid;
    assign wb_reg_write_en  = r_wb_ctrl.reg_write  & r_wb_valid;
    assign wb_mem_to_reg    = r_wb_ctrl.mem_to_reg & r_wb_valid;
    assign wb_rd            = r_wb_rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed plus randomized bench for pipelined_control_unit against a
// stage-level behavioural model of the decode and pipeline rules.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        stall_in;
    logic        flush_in;

    logic       hazard_stall, ex_valid, ex_alu_en, ex_add_imm;
    logic [3:0] ex_alu_op;
    logic       ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_valid, mem_mem_read, mem_mem_write, mem_reg_write_en;
    logic       wb_valid, wb_reg_write_en, wb_mem_to_reg;

    logic       n_hazard_stall, n_ex_valid, n_ex_alu_en, n_ex_add_imm;
    logic [3:0] n_ex_alu_op;
    logic       n_ex_mem_read, n_ex_mem_write, n_ex_branch, n_ex_illegal;
    logic [4:0] n_ex_rd, n_mem_rd, n_wb_rd;
    logic       n_mem_valid, n_mem_mem_read, n_mem_mem_write, n_mem_reg_write_en;
    logic       n_wb_valid, n_wb_reg_write_en, n_wb_mem_to_reg;

    always #5 clk = ~clk;

    pipelined_control_unit #(.LEGACY_ADDI_EN(1), .RF_ADDR_W(5), .HAZARD_EN(1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_alu_en(ex_alu_en), .ex_add_imm(ex_add_imm),
        .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write_en(mem_reg_write_en), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write_en(wb_reg_write_en),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    // Same stimulus into a build with the legacy ADDI opcode disabled.
    pipelined_control_unit #(.LEGACY_ADDI_EN(0), .RF_ADDR_W(5), .HAZARD_EN(1)) dut_nl (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(n_hazard_stall),
        .ex_valid(n_ex_valid), .ex_alu_en(n_ex_alu_en), .ex_add_imm(n_ex_add_imm),
        .ex_alu_op(n_ex_alu_op), .ex_mem_read(n_ex_mem_read), .ex_mem_write(n_ex_mem_write),
        .ex_branch(n_ex_branch), .ex_illegal(n_ex_illegal), .ex_rd(n_ex_rd),
        .mem_valid(n_mem_valid), .mem_mem_read(n_mem_mem_read), .mem_mem_write(n_mem_mem_write),
        .mem_reg_write_en(n_mem_reg_write_en), .mem_rd(n_mem_rd),
        .wb_valid(n_wb_valid), .wb_reg_write_en(n_wb_reg_write_en),
        .wb_mem_to_reg(n_wb_mem_to_reg), .wb_rd(n_wb_rd)
    );

    // One instruction's expected controls; def marks a known rd/alu_op.
    typedef struct packed {
        logic       v;
        logic       def;
        logic       alu_en;
        logic       add_imm;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs2_used;
    } m_t;

    m_t ex_m, mem_m, wb_m;
    int errors = 0;
    int checks = 0;

    function automatic m_t model_decode(logic [31:0] w, bit legacy);
        m_t d;
        d     = '0;
        d.v   = 1'b1;
        d.def = 1'b1;
        d.rd  = w[11:7];
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        case (w[6:0])
            7'b0110011: begin
                d.alu_en = 1; d.reg_write = 1; d.rs2_used = 1;
                d.alu_op = {w[30], w[14:12]};
            end
            7'b0010011: begin
                d.alu_en = 1; d.add_imm = 1; d.reg_write = 1;
                if (w[14:12] == 3'd5) d.alu_op = {w[30], 3'b101};
                else                  d.alu_op = {1'b0, w[14:12]};
            end
            7'b1110011: begin
                if (legacy) begin
                    d.alu_en = 1; d.add_imm = 1; d.reg_write = 1; d.alu_op = 4'd0;
                end else begin
                    d.illegal = 1;
                end
            end
            7'b0000011: begin
                d.add_imm = 1; d.mem_read = 1; d.reg_write = 1; d.mem_to_reg = 1;
            end
            7'b0100011: begin
                d.add_imm = 1; d.mem_write = 1; d.rs2_used = 1;
            end
            7'b1100011: begin
                d.alu_op = 4'b1000; d.branch = 1; d.rs2_used = 1;
            end
            default: d.illegal = 1;
        endcase
        if (d.rd == 5'd0) d.reg_write = 0;
        return d;
    endfunction

    function automatic bit model_hazard(bit iv, logic [31:0] w);
        m_t d;
        if (!iv || !ex_m.v || !ex_m.mem_read || ex_m.rd == 5'd0) return 1'b0;
        d = model_decode(w, 1'b1);
        return (d.rs1 == ex_m.rd) || (d.rs2_used && d.rs2 == ex_m.rd);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stages();
        chk("ex_valid", ex_valid, ex_m.v);
        chk("ex_alu_en", ex_alu_en, ex_m.alu_en & ex_m.v);
        chk("ex_add_imm", ex_add_imm, ex_m.add_imm & ex_m.v);
        chk("ex_mem_read", ex_mem_read, ex_m.mem_read & ex_m.v);
        chk("ex_mem_write", ex_mem_write, ex_m.mem_write & ex_m.v);
        chk("ex_branch", ex_branch, ex_m.branch & ex_m.v);
        chk("ex_illegal", ex_illegal, ex_m.illegal & ex_m.v);
        if (ex_m.def) begin
            chk("ex_alu_op", ex_alu_op, ex_m.alu_op);
            chk("ex_rd", ex_rd, ex_m.rd);
        end
        chk("mem_valid", mem_valid, mem_m.v);
        chk("mem_mem_read", mem_mem_read, mem_m.mem_read & mem_m.v);
        chk("mem_mem_write", mem_mem_write, mem_m.mem_write & mem_m.v);
        chk("mem_reg_write_en", mem_reg_write_en, mem_m.reg_write & mem_m.v);
        if (mem_m.def) chk("mem_rd", mem_rd, mem_m.rd);
        chk("wb_valid", wb_valid, wb_m.v);
        chk("wb_reg_write_en", wb_reg_write_en, wb_m.reg_write & wb_m.v);
        chk("wb_mem_to_reg", wb_mem_to_reg, wb_m.mem_to_reg & wb_m.v);
        if (wb_m.def) chk("wb_rd", wb_rd, wb_m.rd);
    endtask

    // One clock: drive inputs, check the combinational stall, clock, update model, check stages.
    task automatic step(bit r, bit iv, logic [31:0] w, bit st, bit fl);
        bit hz;
        rst = r; instr_valid = iv; instr = w; stall_in = st; flush_in = fl;
        #1;
        hz = r ? 1'b0 : model_hazard(iv, w);
        chk("hazard_stall", hazard_stall, hz);
        @(posedge clk);
        #1;
        if (r) begin
            ex_m = '0;  ex_m.def = 1'b1;
            mem_m = '0; mem_m.def = 1'b1;
            wb_m = '0;  wb_m.def = 1'b1;
        end else if (!st) begin
            wb_m  = mem_m;
            mem_m = ex_m;
            if (iv && !fl && !hz) ex_m = model_decode(w, 1'b1);
            else                  ex_m = '0;
        end
        check_stages();
        $display("t=%0t rst=%0b iv=%0b instr=%08h stall=%0b flush=%0b hz=%0b ex_v=%0b mem_v=%0b wb_v=%0b",
                 $time, r, iv, w, st, fl, hz, ex_valid, mem_valid, wb_valid);
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h407302B3;
    localparam logic [31:0] I_SRAI  = 32'h4020D093;
    localparam logic [31:0] I_LW    = 32'h0000A203;
    localparam logic [31:0] I_ADD54 = 32'h002202B3;
    localparam logic [31:0] I_LEG   = 32'h001083F3;
    localparam logic [31:0] I_ADDI0 = 32'h00100013;

    initial begin
        logic [6:0] ops [8];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1110011; ops[6] = 7'b0000011; ops[7] = 7'b0000000;
        ex_m = '0; mem_m = '0; wb_m = '0;

        step(1, 0, 32'h0, 0, 0);
        step(1, 1, I_ADD, 0, 0);

        step(0, 1, I_ADD, 0, 0);
        chk("add_ex_alu_en", ex_alu_en, 1'b1);
        chk("add_ex_alu_op", ex_alu_op, 4'b0000);
        chk("add_ex_rd", ex_rd, 5'd3);
        step(0, 1, I_SUB, 0, 0);
        chk("sub_ex_alu_op", ex_alu_op, 4'b1000);
        step(0, 1, I_SRAI, 0, 0);
        chk("srai_ex_alu_op", ex_alu_op, 4'b1101);
        chk("srai_ex_add_imm", ex_add_imm, 1'b1);
        chk("add_wb_reg_write_en", wb_reg_write_en, 1'b1);
        chk("add_wb_rd", wb_rd, 5'd3);

        // Load-use: the add is re-presented after the single stall cycle.
        step(0, 1, I_LW, 0, 0);
        step(0, 1, I_ADD54, 0, 0);
        chk("lu_bubble_ex_valid", ex_valid, 1'b0);
        chk("lu_mem_mem_read", mem_mem_read, 1'b1);
        step(0, 1, I_ADD54, 0, 0);
        chk("lu_add_ex_rd", ex_rd, 5'd5);
        chk("lu_add_ex_valid", ex_valid, 1'b1);
        step(0, 0, 32'h0, 0, 0);

        step(0, 1, I_LEG, 0, 0);
        chk("leg_ex_add_imm", ex_add_imm, 1'b1);
        chk("noleg_ex_illegal", n_ex_illegal, 1'b1);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("leg_wb_reg_write_en", wb_reg_write_en, 1'b1);
        chk("noleg_wb_reg_write_en", n_wb_reg_write_en, 1'b0);
        chk("noleg_wb_valid", n_wb_valid, 1'b1);

        step(0, 1, I_ADDI0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("x0_wb_valid", wb_valid, 1'b1);
        chk("x0_wb_reg_write_en", wb_reg_write_en, 1'b0);

        step(0, 1, I_ADD, 0, 0);
        step(0, 1, I_SUB, 1, 1);
        chk("stallflush_ex_valid", ex_valid, 1'b1);
        chk("stallflush_ex_rd", ex_rd, 5'd3);
        step(0, 1, I_SUB, 0, 1);
        chk("flush_ex_valid", ex_valid, 1'b0);
        chk("flush_mem_rd", mem_rd, 5'd3);

        step(0, 1, I_ADD, 0, 0);
        step(0, 1, I_SUB, 0, 0);
        step(0, 1, I_LW, 0, 0);
        step(1, 1, I_ADD, 0, 0);
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_reg_write_en", wb_reg_write_en, 1'b0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] w;
            w        = $urandom;
            w[6:0]   = ops[$urandom_range(0, 7)];
            if (w[6:0] == 7'b0000000) w[6:0] = 7'($urandom);
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0), w,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
